cla_subtractor_32_bit_pipe: RTL and testbench

//  32-bit two-stage pipelined subtractor, the inverse operation of the 32-bit CLA adder datapath.

---
 rtl/cla_pkg.sv | 20 ++
 rtl/cla_sub_16_bit_stage.sv | 72 +++++++
 rtl/cla_subtractor_32_bit_pipe.sv | 112 +++++++++++
 tb/tb_cla_subtractor_32_bit_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared widths and the stage-1 payload layout for the pipelined CLA subtractor.
// No logic lives here.
// Types only; there is no latency or backpressure.
package cla_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_HALF  = 16;
  localparam int CLA_GROUP = 4;

  // Everything stage 2 needs to finish the upper half and the flags.
  typedef struct packed {
    logic [CLA_HALF-1:0] lo;
    logic                c16;
    logic [CLA_HALF-1:0] a_hi;
    logic [CLA_HALF-1:0] nb_hi;
    logic                a31;
    logic                b31;
  } s1_payload_t;

endpackage

// File: rtl/cla_sub_16_bit_stage.sv
// 16-bit carry-lookahead adder built from four 4-bit groups and a 4-group lookahead unit.
// Latency: purely combinational, no state.
// Backpressure: none; the enclosing pipeline stage owns flow control.
module cla_sub_16_bit_stage
  import cla_pkg::*;
#(
  parameter int GROUP_W = CLA_GROUP
) (
  input  logic [CLA_HALF-1:0] x,
  input  logic [CLA_HALF-1:0] y,
  input  logic                cin,
  output logic [CLA_HALF-1:0] sum,
  output logic                cout,
  output logic                grp_p,
  output logic                grp_g
);

  localparam int NGROUP = CLA_HALF / GROUP_W;

  logic [CLA_HALF-1:0] g;
  logic [CLA_HALF-1:0] p;
  logic [NGROUP-1:0]   gg;
  logic [NGROUP-1:0]   gp;
  logic [NGROUP:0]     gc;

  assign g = x & y;
  assign p = x ^ y;

  always_comb begin : group_pg
    logic gk;
    logic pk;
    gg = '0;
    gp = '0;
    for (int k = 0; k < NGROUP; k++) begin
      gk = 1'b0;
      pk = 1'b1;
      for (int j = 0; j < GROUP_W; j++) begin
        gk = g[k*GROUP_W+j] | (p[k*GROUP_W+j] & gk);
        pk = pk & p[k*GROUP_W+j];
      end
      gg[k] = gk;
      gp[k] = pk;
    end
  end

  // Group carry-ins are resolved in parallel from the group generate/propagate terms.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);

  assign grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]);
  assign grp_p = &gp;
  assign gc[4] = grp_g | (grp_p & cin);
  assign cout  = gc[4];

  always_comb begin : group_sum
    logic c;
    sum = '0;
    c   = 1'b0;
    for (int k = 0; k < NGROUP; k++) begin
      c = gc[k];
      for (int j = 0; j < GROUP_W; j++) begin
        sum[k*GROUP_W+j] = p[k*GROUP_W+j] ^ c;
        c = g[k*GROUP_W+j] | (p[k*GROUP_W+j] & c);
      end
    end
  end

endmodule

// File: rtl/cla_subtractor_32_bit_pipe.sv
// Two-stage 32-bit subtractor: diff = a - b - bin computed as a + ~b + ~bin, plus borrow/overflow/zero flags.
// Latency: 2 cycles from accept to out_valid; one beat per cycle.
// Backpressure: valid/ready both sides; in_ready drops only when both stages are full and out_ready is low.
module cla_subtractor_32_bit_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH   = CLA_WIDTH,
  parameter int GROUP_W = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  logic adv1;
  logic adv2;
  logic s1_valid;
  logic s2_valid;

  logic [WIDTH-1:0]    nb;
  logic [CLA_HALF-1:0] lo_sum;
  logic                lo_c16;
  logic                lo_p;
  logic                lo_g;
  logic [CLA_HALF-1:0] hi_sum;
  logic                hi_c32;
  logic                hi_p;
  logic                hi_g;
  logic                unused_grp;

  s1_payload_t      s1_d;
  s1_payload_t      s1_q;
  logic [WIDTH-1:0] diff_d;

  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  assign nb = ~b;

  // Borrow-in is inverted into the adder's carry-in.
  cla_sub_16_bit_stage #(.GROUP_W(GROUP_W)) u_lo (
    .x     (a[CLA_HALF-1:0]),
    .y     (nb[CLA_HALF-1:0]),
    .cin   (~bin),
    .sum   (lo_sum),
    .cout  (lo_c16),
    .grp_p (lo_p),
    .grp_g (lo_g)
  );

  assign s1_d = '{lo:    lo_sum,
                  c16:   lo_c16,
                  a_hi:  a[WIDTH-1:CLA_HALF],
                  nb_hi: nb[WIDTH-1:CLA_HALF],
                  a31:   a[WIDTH-1],
                  b31:   b[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  cla_sub_16_bit_stage #(.GROUP_W(GROUP_W)) u_hi (
    .x     (s1_q.a_hi),
    .y     (s1_q.nb_hi),
    .cin   (s1_q.c16),
    .sum   (hi_sum),
    .cout  (hi_c32),
    .grp_p (hi_p),
    .grp_g (hi_g)
  );

  assign diff_d     = {hi_sum, s1_q.lo};
  assign unused_grp = ^{lo_p, lo_g, hi_p, hi_g};

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        diff <= diff_d;
        bout <= ~hi_c32;
        ovf  <= (s1_q.a31 != s1_q.b31) && (diff_d[WIDTH-1] != s1_q.a31);
        zero <= ~|diff_d;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_cla_subtractor_32_bit_pipe.sv
// Scoreboarded bench for the pipelined 32-bit subtractor: directed corner beats, stall/reset cases, random traffic.
module tb_cla_subtractor_32_bit_pipe;

  typedef struct packed {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  exp_t cur_exp;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   ir_low   = 0;

  cla_subtractor_32_bit_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
    logic [32:0] r;
    exp_t e;
    r      = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
    e.diff = r[31:0];
    e.bout = r[32];
    e.ovf  = (ma[31] != mb[31]) && (r[31] != ma[31]);
    e.zero = (r[31:0] == 32'd0);
    return e;
  endfunction

  // Monitor: occupancy check on in_ready, then pop on output handshake, then push on input handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (sb_q.size() < 2) || out_ready});
      if (!in_ready) ir_low++;
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("diff", diff, e.diff);
          chk("bout", {31'd0, bout}, {31'd0, e.bout});
          chk("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
          chk("zero", {31'd0, zero}, {31'd0, e.zero});
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin, input exp_t e);
    bit ok;
    a        = ta;
    b        = tb_v;
    bin      = tbin;
    cur_exp  = e;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, sb_q.size(), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ovld"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_diff"}, diff, 32'd0);
    chk({tag, "_flags"}, {29'd0, bout, ovf, zero}, 32'd0);
  endtask

  logic [31:0] da  [6] = '{32'h0000_0005, 32'h0000_0000, 32'h1234_5678,
                           32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000};
  logic [31:0] db  [6] = '{32'h0000_0003, 32'h0000_0001, 32'h1234_5678,
                           32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
  logic        dbin[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  exp_t        dexp[6] = '{'{32'h0000_0002, 1'b0, 1'b0, 1'b0},
                           '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0},
                           '{32'h0000_0000, 1'b0, 1'b0, 1'b1},
                           '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0},
                           '{32'h8000_0000, 1'b1, 1'b1, 1'b0},
                           '{32'h0000_FFFE, 1'b0, 1'b0, 1'b0}};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    cur_exp   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // First beat: exact 2-cycle latency.
    send(da[0], db[0], dbin[0], dexp[0]);
    chk("lat1_ovld_e0", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat1_ovld_e1", {31'd0, out_valid}, 32'd1);
    drain("t1_drain");

    for (int i = 1; i < 6; i++) send(da[i], db[i], dbin[i], dexp[i]);
    drain("dir_drain");

    // Back-to-back stream with the consumer stalled for cycles 3..6.
    ir_low = 0;
    n_out  = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] sa;
          logic [31:0] sb;
          sa = 32'h1000_0000 * (i + 1) + i;
          sb = 32'h0100_0003 * i;
          send(sa, sb, i[0], model(sa, sb, i[0]));
        end
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("stream_drain");
    chk("stream_stall_seen", {31'd0, ir_low > 0}, 32'd1);
    chk("stream_count", n_out, 32'd8);

    // Reset with two beats in flight.
    send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, model(32'hDEAD_BEEF, 32'h0000_0001, 1'b0));
    send(32'h0000_0010, 32'h0000_0020, 1'b0, model(32'h0000_0010, 32'h0000_0020, 1'b0));
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    check_idle_outputs("midrst");
    rst = 1'b0;
    send(32'h0000_0009, 32'h0000_0004, 1'b1, model(32'h0000_0009, 32'h0000_0004, 1'b1));
    chk("lat2_ovld_e0", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat2_ovld_e1", {31'd0, out_valid}, 32'd1);
    drain("rst_drain");

    // Random traffic with random backpressure.
    begin
      int  acc;
      int  cyc;
      bit  took;
      acc = 0;
      cyc = 0;
      n_out = 0;
      while (acc < 10000 && cyc < 60000) begin
        if (!in_valid) begin
          logic [31:0] ra;
          logic [31:0] rb;
          logic        rbi;
          ra  = $urandom;
          rb  = $urandom;
          rbi = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 7))
            0: rb = ra;
            1: ra = 32'h8000_0000;
            2: rb = 32'hFFFF_FFFF;
            3: ra = {ra[31:16], 16'h0000};
            default: ;
          endcase
          a        = ra;
          b        = rb;
          bin      = rbi;
          cur_exp  = model(ra, rb, rbi);
          in_valid = ($urandom_range(0, 9) < 7);
        end
        out_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);
        took = in_valid && in_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (took) begin
          acc++;
          in_valid = 1'b0;
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("rand_accepted", acc, 32'd10000);
      drain("rand_drain");
      chk("rand_count", n_out, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
